// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - light-level to PWM stage with per-period duty fading (PWM_FADE_EN selects stepped fade, else single jump)
module pwm_fade_ctrl #(
  parameter int unsigned STEP = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic [2:0] i_level,
  output logic       o_pwm,
  output logic [9:0] o_duty,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

`ifdef PWM_FADE_EN
  localparam logic [10:0] STEP_AMT = 11'(STEP);
`else
  // A step no smaller than the full duty range lets one boundary reach any target.
  localparam logic [10:0] STEP_AMT = 11'(STEP) | 11'd1023;
`endif

  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  duty_q, duty_d;
  logic [9:0]  target_q, target_d;
  logic        pwm_q, pwm_d;
  state_t      state_q, state_d;
  logic        boundary;
  logic [10:0] sum;
  logic [10:0] diff;

  // Map the light state onto its duty target; out-of-range states mean off.
  always_comb begin
    target_d = 10'd0;
    case (i_level)
      3'd1:    target_d = 10'd256;
      3'd2:    target_d = 10'd512;
      3'd3:    target_d = 10'd768;
      3'd4:    target_d = 10'd1023;
      default: target_d = 10'd0;
    endcase
  end

  // Free-running period counter; the last tick of a period is the only place duty may move.
  always_comb begin
    cnt_d    = cnt_q;
    boundary = i_tick && (cnt_q == 10'd1023);
    if (i_tick) begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  // Fade direction follows the live duty/target comparison every cycle.
  always_comb begin
    state_d = ST_IDLE;
    if (duty_q < target_q) begin
      state_d = ST_UP;
    end else if (duty_q > target_q) begin
      state_d = ST_DOWN;
    end
  end

  // Step duty toward target at a boundary, clamping so it never overshoots.
  always_comb begin
    duty_d = duty_q;
    sum    = {1'b0, duty_q} + STEP_AMT;
    diff   = {1'b0, duty_q} - STEP_AMT;
    if (boundary) begin
      case (state_d)
        ST_UP:   duty_d = (sum >= {1'b0, target_q}) ? target_q : sum[9:0];
        ST_DOWN: duty_d = (diff[10] || (diff <= {1'b0, target_q})) ? target_q : diff[9:0];
        default: duty_d = duty_q;
      endcase
    end
  end

  // Full-scale duty must stay high across the counter wrap.
  always_comb begin
    pwm_d = (cnt_q < duty_q) || (duty_q == 10'd1023);
  end

  // State registers; reset forces the lamp off immediately.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q    <= 10'd0;
      duty_q   <= 10'd0;
      target_q <= 10'd0;
      pwm_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      pwm_q    <= pwm_d;
      state_q  <= state_d;
    end
  end

  assign o_pwm  = pwm_q;
  assign o_duty = duty_q;
  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - self-checking bench for pwm_fade_ctrl (both PWM_FADE_EN builds)
module tb_pwm_fade_ctrl;

  localparam int TB_STEP = 128;

  logic       clk;
  logic       i_reset;
  logic       i_tick;
  logic [2:0] i_level;
  logic       o_pwm;
  logic [9:0] o_duty;
  logic       o_busy;

  pwm_fade_ctrl #(.STEP(TB_STEP)) dut (
    .i_clk  (clk),
    .i_reset(i_reset),
    .i_tick (i_tick),
    .i_level(i_level),
    .o_pwm  (o_pwm),
    .o_duty (o_duty),
    .o_busy (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] duty;
    logic       busy;
    logic       pwm;
  } exp_t;

  typedef struct {
    logic [2:0] level;
    int         exp_duty;
    int         exp_high;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[7];

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt = 0, m_duty = 0, m_target = 0, m_busy = 0, m_pwm = 0;
  int nbound = 0;

  function automatic int lut(input logic [2:0] l);
    case (l)
      3'd1:    return 256;
      3'd2:    return 512;
      3'd3:    return 768;
      3'd4:    return 1023;
      default: return 0;
    endcase
  endfunction

  task automatic bail_if_flooded();
    if (n_fail > 200) begin
      $display("FAIL abort: more than 200 failures");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
      bail_if_flooded();
    end
  endtask

  // Drive one cycle, advance the reference model, compare after the edge.
  task automatic step(input logic rst, input logic tick, input logic [2:0] lvl);
    int   nd;
    exp_t e;
    exp_t got;
    i_reset = rst;
    i_tick  = tick;
    i_level = lvl;
    if (rst) begin
      m_cnt = 0; m_duty = 0; m_target = 0; m_busy = 0; m_pwm = 0;
    end else begin
      nd = m_duty;
      if (tick && m_cnt == 1023) begin
        nbound++;
        if (m_duty != m_target) begin
`ifdef PWM_FADE_EN
          if (m_duty < m_target) nd = (m_duty + TB_STEP > m_target) ? m_target : m_duty + TB_STEP;
          else                   nd = (m_duty - TB_STEP < m_target) ? m_target : m_duty - TB_STEP;
`else
          nd = m_target;
`endif
        end
      end
      m_pwm    = ((m_cnt < m_duty) || (m_duty == 1023)) ? 1 : 0;
      m_busy   = (m_duty != m_target) ? 1 : 0;
      m_cnt    = tick ? (m_cnt + 1) % 1024 : m_cnt;
      m_target = lut(lvl);
      m_duty   = nd;
    end
    e.duty = 10'(m_duty);
    e.busy = m_busy[0];
    e.pwm  = m_pwm[0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    got = {o_duty, o_busy, o_pwm};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL cycle t=%0t: duty/busy/pwm got %0d/%0b/%0b expected %0d/%0b/%0b",
               $time, o_duty, o_busy, o_pwm, e.duty, e.busy, e.pwm);
      bail_if_flooded();
    end
  endtask

  task automatic align(input logic [2:0] lvl);
    for (int c = 0; c < 1100 && m_cnt != 0; c++) step(1'b0, 1'b1, lvl);
  endtask

  // Apply a level with continuous ticks until the output settles on the expected duty.
  task automatic settle(input int exp_duty, input int prev_duty, input logic [2:0] lvl, input string name);
    int start_b, exp_p, d;
    bit done;
    start_b = nbound;
    done    = 0;
    for (int c = 0; c < 12 * 1024 && !done; c++) begin
      step(1'b0, 1'b1, lvl);
      if (o_duty == 10'(exp_duty) && !o_busy) done = 1;
    end
    check({name, " settled"}, int'(done), 1);
    check({name, " duty"}, int'(o_duty), exp_duty);
    d = (exp_duty > prev_duty) ? exp_duty - prev_duty : prev_duty - exp_duty;
`ifdef PWM_FADE_EN
    exp_p = (d + TB_STEP - 1) / TB_STEP;
`else
    exp_p = (d != 0) ? 1 : 0;
`endif
    check({name, " periods"}, nbound - start_b, exp_p);
  endtask

  task automatic measure(input int exp_high, input logic [2:0] lvl, input string name);
    int hi;
    hi = 0;
    step(1'b0, 1'b1, lvl);
    for (int c = 0; c < 1024; c++) begin
      step(1'b0, 1'b1, lvl);
      hi += int'(o_pwm);
    end
    check({name, " high ticks"}, hi, exp_high);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int  prev;
    bit  done;
    tbl[0] = '{3'd2, 512,  512};
    tbl[1] = '{3'd4, 1023, 1024};
    tbl[2] = '{3'd0, 0,    0};
    tbl[3] = '{3'd3, 768,  768};
    tbl[4] = '{3'd6, 0,    0};
    tbl[5] = '{3'd1, 256,  256};
    tbl[6] = '{3'd7, 0,    0};

    i_reset = 1'b1; i_tick = 1'b0; i_level = 3'd0;

    for (int i = 0; i < 8; i++) step(1'b1, 1'(i % 2), 3'd4);
    check("reset duty", int'(o_duty), 0);
    check("reset busy", int'(o_busy), 0);
    check("reset pwm", int'(o_pwm), 0);

    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 3'd0);
    check("idle duty", int'(o_duty), 0);
    check("idle busy", int'(o_busy), 0);

    prev = 0;
    for (int i = 0; i < 7; i++) begin
      settle(tbl[i].exp_duty, prev, tbl[i].level, $sformatf("vec%0d", i));
      measure(tbl[i].exp_high, tbl[i].level, $sformatf("vec%0d", i));
      prev = tbl[i].exp_duty;
    end

    for (int i = 0; i < 1500; i++) step(1'b0, 1'($urandom_range(0, 1)), 3'd2);
    done = 0;
    for (int c = 0; c < 6 * 1024 && !done; c++) begin
      step(1'b0, 1'b1, 3'd2);
      if (o_duty == 10'd512 && !o_busy) done = 1;
    end
    check("gapped tick reaches 512", int'(done), 1);
    align(3'd2);
    settle(0, 512, 3'd0, "back to 0");
    measure(0, 3'd0, "off");

`ifdef PWM_FADE_EN
    done = 0;
    for (int c = 0; c < 4 * 1024 && !done; c++) begin
      step(1'b0, 1'b1, 3'd3);
      if (o_duty == 10'd256) done = 1;
    end
    check("rev reach 256", int'(done), 1);
    done = 0;
    for (int c = 0; c < 1100 && !done; c++) begin
      step(1'b0, 1'b1, 3'd0);
      if (o_duty != 10'd256) done = 1;
    end
    check("rev first down step", int'(o_duty), 256 - TB_STEP);
    check("rev busy", int'(o_busy), 1);
    settle(0, 256 - TB_STEP, 3'd0, "rev to 0");
    measure(0, 3'd0, "rev off");
`else
    step(1'b0, 1'b1, 3'd3);
    step(1'b0, 1'b1, 3'd3);
    check("jump busy on change", int'(o_busy), 1);
    step(1'b0, 1'b1, 3'd0);
    step(1'b0, 1'b1, 3'd0);
    check("jump busy cancelled", int'(o_busy), 0);
    for (int c = 0; c < 1100; c++) step(1'b0, 1'b1, 3'd0);
    check("jump duty stays 0", int'(o_duty), 0);
`endif

    align(3'd0);
    settle(768, 0, 3'd3, "up to 768");
    for (int c = 0; c < 300; c++) step(1'b0, 1'b1, 3'd6);
`ifdef PWM_FADE_EN
    for (int c = 0; c < 1024; c++) step(1'b0, 1'b1, 3'd6);
    check("mid fade duty", int'(o_duty), 768 - TB_STEP);
`endif
    check("busy before reset", int'(o_busy), 1);
    step(1'b1, 1'b1, 3'd6);
    check("mid reset duty", int'(o_duty), 0);
    check("mid reset busy", int'(o_busy), 0);
    check("mid reset pwm", int'(o_pwm), 0);
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 3'd0);
    check("post reset duty", int'(o_duty), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
